// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
// Sends one character per ready/valid handshake, LSB first. The character
// width is fixed at build time. Parity and stop-bit count are latched per
// frame together with the data, so input changes after accept cannot
// disturb a frame in flight.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   s_valid      character available on s_data
//   s_ready      transmitter can accept a character this cycle (IDLE)
//   s_data       character, DATA_WIDTH bits
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop2        0 = one stop bit, 1 = two stop bits
//   tx           serial line, idle high, registered
//   busy         frame in progress
//   tx_done      one-cycle pulse in the first IDLE cycle after a frame
//
// state  | meaning
// IDLE   | line high, waiting for s_valid
// START  | start bit (low) for DIV cycles
// DATA   | data bit bit_cnt for DIV cycles, bits 0..DATA_WIDTH-1
// PARITY | parity bit for DIV cycles (even/odd mode only)
// STOP   | stop bit(s) high; bit_cnt counts the second stop bit
module uart_tx_cfg #(
   parameter int CLOCK_SPEED = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic [1:0]            parity_mode,
   input  logic                  stop2,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int DIV    = CLOCK_SPEED / BAUD_RATE;
   localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   if (DIV < 2) begin : g_div_check
      $error("uart_tx_cfg: CLOCK_SPEED / BAUD_RATE must be at least 2");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
      $error("uart_tx_cfg: DATA_WIDTH must be in 5..9");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            par_mode_q, par_mode_d;
   logic                  stop2_q, stop2_d;
   logic                  tx_q, tx_d;
   logic                  tx_done_q, tx_done_d;

   logic                  baud_last;
   logic                  parity_en;
   logic                  parity_bit;
   logic [DATA_WIDTH-1:0] data_shift;

   assign baud_last  = (baud_cnt_q == BAUD_LAST);
   assign parity_en  = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
   assign parity_bit = (^data_q) ^ (par_mode_q == 2'b10);
   assign data_shift = data_q >> bit_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_mode_q <= '0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         par_mode_q <= par_mode_d;
         stop2_q    <= stop2_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_mode_d = par_mode_q;
      stop2_d    = stop2_q;
      tx_done_d  = 1'b0;

      if (state_q != S_IDLE) begin
         baud_cnt_d = baud_last ? '0 : baud_cnt_q + BAUD_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               data_d     = s_data;
               par_mode_d = parity_mode;
               stop2_d    = stop2;
               bit_cnt_d  = '0;
               baud_cnt_d = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = parity_en ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               // bit_cnt is 0 during the first stop bit, 1 during the second
               if (stop2_q && (bit_cnt_q == '0)) begin
                  bit_cnt_d = BIT_W'(1);
               end else begin
                  bit_cnt_d = '0;
                  state_d   = S_IDLE;
                  tx_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The line level is registered from the current state, so it lags the
   // state register by one cycle: accept at edge 0, start bit from edge 1.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_shift[0];
         S_PARITY: tx_d = parity_bit;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   assign s_ready = (state_q == S_IDLE);
   assign busy    = !s_ready;
   assign tx      = tx_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int DIV    = CLK_HZ / BAUD;

   logic            clk;
   logic            clk_en;
   logic            rst;
   logic [2:0]      s_valid;
   logic [2:0][1:0] pm;
   logic [2:0]      st2;
   logic [2:0]      s_ready;
   logic [2:0]      busy;
   logic [2:0]      tx_w;
   logic [2:0]      done;
   logic [7:0]      sd0;
   logic [4:0]      sd1;
   logic [8:0]      sd2;

   int n_vec;
   int n_bad;
   bit exp_q[$];

   uart_tx_cfg #(.CLOCK_SPEED(CLK_HZ), .BAUD_RATE(BAUD), .DATA_WIDTH(8)) u_dw8 (
      .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
      .s_data(sd0), .parity_mode(pm[0]), .stop2(st2[0]),
      .tx(tx_w[0]), .busy(busy[0]), .tx_done(done[0]));

   uart_tx_cfg #(.CLOCK_SPEED(CLK_HZ), .BAUD_RATE(BAUD), .DATA_WIDTH(5)) u_dw5 (
      .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
      .s_data(sd1), .parity_mode(pm[1]), .stop2(st2[1]),
      .tx(tx_w[1]), .busy(busy[1]), .tx_done(done[1]));

   uart_tx_cfg #(.CLOCK_SPEED(CLK_HZ), .BAUD_RATE(BAUD), .DATA_WIDTH(9)) u_dw9 (
      .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
      .s_data(sd2), .parity_mode(pm[2]), .stop2(st2[2]),
      .tx(tx_w[2]), .busy(busy[2]), .tx_done(done[2]));

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int dw_of(input int u);
      return (u == 0) ? 8 : (u == 1) ? 5 : 9;
   endfunction

   task automatic set_data(input int u, input logic [8:0] d);
      case (u)
         0: sd0 = d[7:0];
         1: sd1 = d[4:0];
         default: sd2 = d;
      endcase
   endtask

   // Expected line bits for one frame, one entry per bit slot.
   task automatic build_frame(input int w, input logic [8:0] d, input logic [1:0] p,
                              input logic s2);
      int ones;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < w; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (p == 2'b01) exp_q.push_back((ones % 2) == 1);
      if (p == 2'b10) exp_q.push_back((ones % 2) == 0);
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);
   endtask

   // Accepts one character on unit u at the next edge and checks every
   // cycle of the frame. keep_valid leaves s_valid high and presents
   // next_d, so the following call starts on the back-to-back accept.
   task automatic run_frame(input int u, input logic [8:0] d, input logic [1:0] p,
                            input logic s2, input bit keep_valid, input logic [8:0] next_d,
                            input bit scramble, input string tag);
      int   total;
      int   slot;
      logic slot_obs;
      logic ctl_bad;
      build_frame(dw_of(u), d, p, s2);
      total = exp_q.size() * DIV;
      chk({tag, " ready_before"}, s_ready[u], 1'b1);
      set_data(u, d);
      pm[u]      = p;
      st2[u]     = s2;
      s_valid[u] = 1'b1;
      tick();
      if (keep_valid) set_data(u, next_d);
      else s_valid[u] = 1'b0;
      chk({tag, " busy_after_accept"}, {busy[u], s_ready[u]}, 2'b10);
      ctl_bad  = 1'b0;
      slot_obs = 1'b0;
      for (int n = 1; n <= total; n++) begin
         tick();
         slot = (n - 1) / DIV;
         if ((n - 1) % DIV == 0) slot_obs = tx_w[u];
         else if (tx_w[u] !== exp_q[slot]) slot_obs = tx_w[u];
         if (n < total && (done[u] !== 1'b0 || busy[u] !== 1'b1)) ctl_bad = 1'b1;
         if (n % DIV == 0) chk($sformatf("%s slot%0d", tag, slot), slot_obs, exp_q[slot]);
         if (scramble && n == 25) begin
            set_data(u, 9'($urandom));
            pm[u]  = 2'($urandom);
            st2[u] = 1'($urandom);
         end
      end
      chk({tag, " ctl_in_frame"}, ctl_bad, 1'b0);
      chk({tag, " done_ready_idle"}, {done[u], s_ready[u], busy[u]}, 3'b110);
      if (!keep_valid) begin
         tick();
         chk({tag, " done_one_cycle"}, done[u], 1'b0);
      end
   endtask

   initial begin
      logic       rst_bad;
      logic [8:0] d;
      n_vec   = 0;
      n_bad   = 0;
      clk_en  = 1'b0;
      s_valid = '0;
      pm      = '0;
      st2     = '0;
      sd0     = '0;
      sd1     = '0;
      sd2     = '0;
      rst     = 1'b1;
      #3;
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("reset_noclk u%0d", u), {tx_w[u], s_ready[u], busy[u], done[u]}, 4'b1100);
      end
      clk_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_frame(0, 9'h0A5, 2'b00, 1'b0, 1'b0, 9'h0, 1'b0, "8N1_A5");
      run_frame(0, 9'h007, 2'b01, 1'b0, 1'b0, 9'h0, 1'b0, "even_07");
      run_frame(0, 9'h007, 2'b10, 1'b0, 1'b0, 9'h0, 1'b0, "odd_07");
      run_frame(0, 9'h007, 2'b11, 1'b0, 1'b0, 9'h0, 1'b0, "rsvd_07");
      run_frame(0, 9'h0C6, 2'b01, 1'b1, 1'b0, 9'h0, 1'b0, "even_stop2");
      run_frame(0, 9'h0C6, 2'b00, 1'b1, 1'b0, 9'h0, 1'b0, "none_stop2");

      run_frame(0, 9'h055, 2'b00, 1'b0, 1'b1, 9'h00F, 1'b0, "b2b_first");
      run_frame(0, 9'h00F, 2'b00, 1'b0, 1'b0, 9'h0, 1'b0, "b2b_second");

      run_frame(0, 9'h03C, 2'b01, 1'b0, 1'b0, 9'h0, 1'b1, "scramble");

      // Reset in the middle of data bit 4 abandons the frame.
      set_data(0, 9'h0C3);
      pm[0]      = 2'b00;
      st2[0]     = 1'b0;
      s_valid[0] = 1'b1;
      tick();
      s_valid[0] = 1'b0;
      for (int n = 0; n < 55; n++) tick();
      rst = 1'b1;
      #1;
      chk("rst_midframe", {tx_w[0], s_ready[0], busy[0], done[0]}, 4'b1100);
      tick();
      tick();
      rst = 1'b0;
      rst_bad = 1'b0;
      for (int n = 0; n < 120; n++) begin
         tick();
         if (tx_w[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) rst_bad = 1'b1;
      end
      chk("rst_quiet_after", rst_bad, 1'b0);
      run_frame(0, 9'h05A, 2'b10, 1'b0, 1'b0, 9'h0, 1'b0, "after_rst");

      run_frame(1, 9'h01F, 2'b01, 1'b0, 1'b0, 9'h0, 1'b0, "dw5_1F_even");
      run_frame(2, 9'h1AB, 2'b01, 1'b0, 1'b0, 9'h0, 1'b0, "dw9_1AB_even");

      for (int i = 0; i < 20; i++) begin
         d = 9'($urandom);
         run_frame(0, d, 2'($urandom), 1'($urandom), 1'b0, 9'h0, 1'($urandom),
                   $sformatf("rnd8_%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         run_frame(1, 9'($urandom), 2'($urandom), 1'($urandom), 1'b0, 9'h0, 1'b0,
                   $sformatf("rnd5_%0d", i));
         run_frame(2, 9'($urandom), 2'($urandom), 1'($urandom), 1'b0, 9'h0, 1'b0,
                   $sformatf("rnd9_%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
